// File: rtl/rf_pkg.sv
// Shared constants and types for the rename register file (rf_rename_mc).
package rf_pkg;
  localparam int REG_NUM  = 32;
  localparam int ROB_W    = 4;
  localparam int SNAP_NUM = 4;
  localparam int SNAP_W   = $clog2(SNAP_NUM);
  localparam int ISSUE_W  = 2;
  localparam int COMMIT_W = 2;
  localparam int XLEN     = 32;
  localparam int RIDX_W   = 5;

  typedef logic [ROB_W-1:0]  rf_tag_t;
  typedef logic [RIDX_W-1:0] rf_idx_t;

  localparam rf_idx_t ZERO_REG = '0;
endpackage

// File: rtl/rf_rename_mc_if.sv
// Dispatcher/ROB-facing bundle of rf_rename_mc: issue lookups, renames, commits, checkpoints.
interface rf_rename_mc_if;
  import rf_pkg::*;

  logic [ISSUE_W-1:0]        issue_valid;
  logic [ISSUE_W*RIDX_W-1:0] issue_rs1;
  logic [ISSUE_W*RIDX_W-1:0] issue_rs2;
  logic [ISSUE_W*RIDX_W-1:0] issue_rd;
  logic [ISSUE_W-1:0]        rename_valid;
  logic [ISSUE_W*ROB_W-1:0]  issue_rdTag;
  logic [ISSUE_W*ROB_W-1:0]  issue_Qj;
  logic [ISSUE_W*ROB_W-1:0]  issue_Qk;
  logic [ISSUE_W*XLEN-1:0]   issue_Vj;
  logic [ISSUE_W*XLEN-1:0]   issue_Vk;
  logic [ISSUE_W-1:0]        issue_Rj;
  logic [ISSUE_W-1:0]        issue_Rk;
  logic [COMMIT_W-1:0]        commit_valid;
  logic [COMMIT_W*RIDX_W-1:0] commit_rd;
  logic [COMMIT_W*ROB_W-1:0]  commit_tag;
  logic [COMMIT_W*XLEN-1:0]   commit_val;
  logic              snap_valid;
  logic [SNAP_W-1:0] snap_id;
  logic              rollback;
  logic [SNAP_W-1:0] rollback_id;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, rename_valid, issue_rdTag,
    output commit_valid, commit_rd, commit_tag, commit_val,
    output snap_valid, snap_id, rollback, rollback_id,
    input  issue_Qj, issue_Qk, issue_Vj, issue_Vk, issue_Rj, issue_Rk
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, rename_valid, issue_rdTag,
    input  commit_valid, commit_rd, commit_tag, commit_val,
    input  snap_valid, snap_id, rollback, rollback_id,
    output issue_Qj, issue_Qk, issue_Vj, issue_Vk, issue_Rj, issue_Rk
  );
endinterface

// File: rtl/rf_snapshot_bank.sv
// Rename checkpoint storage; present only when RF_CHECKPOINT_EN is defined, otherwise the
// restored table reads as all-idle so a rollback simply clears every tag and busy bit.
module rf_snapshot_bank
  import rf_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rdy,
  input  logic                          save_en,
  input  logic [SNAP_W-1:0]             save_id,
  input  rf_tag_t [REG_NUM-1:0]         save_tag,
  input  logic [REG_NUM-1:0]            save_busy,
  input  logic [COMMIT_W-1:0]           commit_valid,
  input  rf_tag_t [COMMIT_W-1:0]        commit_tag,
  input  logic [SNAP_W-1:0]             restore_id,
  output rf_tag_t [REG_NUM-1:0]         restore_tag,
  output logic [REG_NUM-1:0]            restore_busy
);
`ifdef RF_CHECKPOINT_EN
  rf_tag_t [REG_NUM-1:0] snap_tag_reg  [SNAP_NUM];
  logic [REG_NUM-1:0]    snap_busy_reg [SNAP_NUM];
  logic [REG_NUM-1:0]    busy_clr      [SNAP_NUM];

  generate
    for (genvar gi = 0; gi < SNAP_NUM; gi++) begin : g_slot
      // A retiring tag can be live in any saved table, whichever register it renamed.
      always_comb begin
        busy_clr[gi] = snap_busy_reg[gi];
        for (int r = 0; r < REG_NUM; r++) begin
          for (int k = 0; k < COMMIT_W; k++) begin
            if (commit_valid[k] && snap_tag_reg[gi][r] == commit_tag[k]) begin
              busy_clr[gi][r] = 1'b0;
            end
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          snap_tag_reg[gi]  <= '0;
          snap_busy_reg[gi] <= '0;
        end else if (rdy) begin
          if (save_en && save_id == SNAP_W'(gi)) begin
            snap_tag_reg[gi]  <= save_tag;
            snap_busy_reg[gi] <= save_busy;
          end else begin
            snap_busy_reg[gi] <= busy_clr[gi];
          end
        end
      end
    end
  endgenerate

  assign restore_tag  = snap_tag_reg[restore_id];
  assign restore_busy = busy_clr[restore_id];
`else
  logic unused_bank;
  assign unused_bank  = ^{clk, rst_n, rdy, save_en, save_id, save_tag, save_busy,
                          commit_valid, commit_tag, restore_id};
  assign restore_tag  = '0;
  assign restore_busy = '0;
`endif
endmodule

// File: rtl/rf_rename_mc.sv
// Multi-lane register file + rename status table with operand lookup priority logic.
// Build option RF_CHECKPOINT_EN enables per-branch rename checkpoints for rollback.
module rf_rename_mc
  import rf_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rdy,
  rf_rename_mc_if.slave bus
);
  logic [REG_NUM-1:0][XLEN-1:0] reg_val_reg, val_next;
  rf_tag_t [REG_NUM-1:0]        reg_tag_reg, tag_next;
  logic [REG_NUM-1:0]           reg_busy_reg, busy_next;
  rf_tag_t [REG_NUM-1:0]        restore_tag;
  logic [REG_NUM-1:0]           restore_busy;

  rf_tag_t [1:0][ISSUE_W-1:0]         lk_q;
  logic    [1:0][ISSUE_W-1:0][XLEN-1:0] lk_v;
  logic    [1:0][ISSUE_W-1:0]         lk_r;

  always_comb begin : p_lookup
    rf_idx_t rs;
    logic    hit;
    logic    fwd;
    lk_q = '0;
    lk_v = '0;
    lk_r = '0;
    for (int n = 0; n < ISSUE_W; n++) begin
      for (int s = 0; s < 2; s++) begin
        rs  = (s == 0) ? bus.issue_rs1[n*RIDX_W +: RIDX_W] : bus.issue_rs2[n*RIDX_W +: RIDX_W];
        hit = 1'b0;
        fwd = 1'b0;
        if (bus.issue_valid[n]) begin
          if (rs == ZERO_REG) begin
            lk_r[s][n] = 1'b1;
          end else begin
            // Ascending scans let the youngest matching lane overwrite older ones.
            for (int m = 0; m < n; m++) begin
              if (bus.rename_valid[m] && bus.issue_rd[m*RIDX_W +: RIDX_W] == rs) begin
                hit        = 1'b1;
                lk_q[s][n] = bus.issue_rdTag[m*ROB_W +: ROB_W];
              end
            end
            if (!hit) begin
              for (int k = 0; k < COMMIT_W; k++) begin
                if (bus.commit_valid[k] && bus.commit_rd[k*RIDX_W +: RIDX_W] == rs &&
                    (!reg_busy_reg[rs] || reg_tag_reg[rs] == bus.commit_tag[k*ROB_W +: ROB_W])) begin
                  fwd        = 1'b1;
                  lk_v[s][n] = bus.commit_val[k*XLEN +: XLEN];
                end
              end
              if (fwd) begin
                lk_r[s][n] = 1'b1;
              end else if (!reg_busy_reg[rs]) begin
                lk_r[s][n] = 1'b1;
                lk_v[s][n] = reg_val_reg[rs];
              end else begin
                lk_q[s][n] = reg_tag_reg[rs];
              end
            end
          end
        end
      end
    end
  end

  assign bus.issue_Qj = lk_q[0];
  assign bus.issue_Qk = lk_q[1];
  assign bus.issue_Vj = lk_v[0];
  assign bus.issue_Vk = lk_v[1];
  assign bus.issue_Rj = lk_r[0];
  assign bus.issue_Rk = lk_r[1];

  always_comb begin : p_next
    rf_idx_t idx;
    val_next  = reg_val_reg;
    tag_next  = reg_tag_reg;
    busy_next = reg_busy_reg;
    for (int k = 0; k < COMMIT_W; k++) begin
      idx = bus.commit_rd[k*RIDX_W +: RIDX_W];
      if (bus.commit_valid[k] && idx != ZERO_REG) begin
        val_next[idx] = bus.commit_val[k*XLEN +: XLEN];
        if (reg_busy_reg[idx] && reg_tag_reg[idx] == bus.commit_tag[k*ROB_W +: ROB_W]) begin
          busy_next[idx] = 1'b0;
        end
      end
    end
    // Renames come last so a same-cycle rename re-asserts busy over any commit clear.
    for (int n = 0; n < ISSUE_W; n++) begin
      idx = bus.issue_rd[n*RIDX_W +: RIDX_W];
      if (bus.rename_valid[n] && idx != ZERO_REG) begin
        tag_next[idx]  = bus.issue_rdTag[n*ROB_W +: ROB_W];
        busy_next[idx] = 1'b1;
      end
    end
  end

  rf_snapshot_bank u_snap (
    .clk          (clk),
    .rst_n        (rst_n),
    .rdy          (rdy),
    .save_en      (bus.snap_valid & ~bus.rollback),
    .save_id      (bus.snap_id),
    .save_tag     (tag_next),
    .save_busy    (busy_next),
    .commit_valid (bus.commit_valid),
    .commit_tag   (bus.commit_tag),
    .restore_id   (bus.rollback_id),
    .restore_tag  (restore_tag),
    .restore_busy (restore_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_val_reg  <= '0;
      reg_tag_reg  <= '0;
      reg_busy_reg <= '0;
    end else if (rdy) begin
      reg_val_reg <= val_next;
      if (bus.rollback) begin
        reg_tag_reg  <= restore_tag;
        reg_busy_reg <= restore_busy;
      end else begin
        reg_tag_reg  <= tag_next;
        reg_busy_reg <= busy_next;
      end
    end
  end
endmodule

// File: tb/tb_rf_rename_mc.sv
// Directed bench for rf_rename_mc: hand-computed lookup results per scenario.
module tb_rf_rename_mc;
  import rf_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rdy   = 1'b0;
  int vectors     = 0;
  int miscompares = 0;

  rf_rename_mc_if bus();

  rf_rename_mc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {Q, R, V} of one lane's j or k operand
  function automatic logic [36:0] obs_j(input int lane);
    return {bus.issue_Qj[lane*ROB_W +: ROB_W], bus.issue_Rj[lane], bus.issue_Vj[lane*XLEN +: XLEN]};
  endfunction

  function automatic logic [36:0] obs_k(input int lane);
    return {bus.issue_Qk[lane*ROB_W +: ROB_W], bus.issue_Rk[lane], bus.issue_Vk[lane*XLEN +: XLEN]};
  endfunction

  task automatic idle_inputs();
    bus.issue_valid  = '0;
    bus.issue_rs1    = '0;
    bus.issue_rs2    = '0;
    bus.issue_rd     = '0;
    bus.rename_valid = '0;
    bus.issue_rdTag  = '0;
    bus.commit_valid = '0;
    bus.commit_rd    = '0;
    bus.commit_tag   = '0;
    bus.commit_val   = '0;
    bus.snap_valid   = 1'b0;
    bus.snap_id      = '0;
    bus.rollback     = 1'b0;
    bus.rollback_id  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic lookup(input int lane, input int rs1, input int rs2);
    bus.issue_valid[lane]               = 1'b1;
    bus.issue_rs1[lane*RIDX_W +: RIDX_W] = RIDX_W'(rs1);
    bus.issue_rs2[lane*RIDX_W +: RIDX_W] = RIDX_W'(rs2);
  endtask

  task automatic rename(input int lane, input int rd, input int tag);
    bus.rename_valid[lane]               = 1'b1;
    bus.issue_rd[lane*RIDX_W +: RIDX_W]   = RIDX_W'(rd);
    bus.issue_rdTag[lane*ROB_W +: ROB_W]  = ROB_W'(tag);
  endtask

  task automatic commit(input int lane, input int rd, input int tag, input logic [31:0] val);
    bus.commit_valid[lane]              = 1'b1;
    bus.commit_rd[lane*RIDX_W +: RIDX_W] = RIDX_W'(rd);
    bus.commit_tag[lane*ROB_W +: ROB_W]  = ROB_W'(tag);
    bus.commit_val[lane*XLEN +: XLEN]    = val;
  endtask

  task automatic test_reset();
    lookup(0, 5, 0);
    lookup(1, 31, 1);
    #1;
    vectors++;
    if (obs_j(0) !== {4'd0, 1'b1, 32'd0}) begin
      miscompares++; $display("FAIL reset_l0_j: got %h want %h", obs_j(0), {4'd0, 1'b1, 32'd0});
    end
    vectors++;
    if (obs_j(1) !== {4'd0, 1'b1, 32'd0}) begin
      miscompares++; $display("FAIL reset_l1_j: got %h want %h", obs_j(1), {4'd0, 1'b1, 32'd0});
    end
    vectors++;
    if (obs_k(1) !== {4'd0, 1'b1, 32'd0}) begin
      miscompares++; $display("FAIL reset_l1_k: got %h want %h", obs_k(1), {4'd0, 1'b1, 32'd0});
    end
    $display("[%0t] test_reset done", $time);
    tick();
  endtask

  task automatic test_intra_group();
    rename(0, 7, 2);
    lookup(0, 7, 0);
    lookup(1, 7, 0);
    #1;
    vectors++;
    if (obs_j(1) !== {4'd2, 1'b0, 32'd0}) begin
      miscompares++; $display("FAIL intra_l1_j: got %h want %h", obs_j(1), {4'd2, 1'b0, 32'd0});
    end
    vectors++;
    if (obs_j(0) !== {4'd0, 1'b1, 32'd0}) begin
      miscompares++; $display("FAIL intra_l0_self: got %h want %h", obs_j(0), {4'd0, 1'b1, 32'd0});
    end
    tick();
    lookup(0, 7, 7);
    bus.issue_rs1[RIDX_W +: RIDX_W] = 5'd7;  // lane 1 addressed but not valid
    #1;
    vectors++;
    if (obs_k(0) !== {4'd2, 1'b0, 32'd0}) begin
      miscompares++; $display("FAIL intra_next_busy: got %h want %h", obs_k(0), {4'd2, 1'b0, 32'd0});
    end
    vectors++;
    if (obs_j(1) !== 37'd0) begin
      miscompares++; $display("FAIL intra_invalid_lane: got %h want %h", obs_j(1), 37'd0);
    end
    $display("[%0t] test_intra_group done", $time);
    tick();
  endtask

  task automatic test_dual_commit();
    rename(0, 4, 2);
    tick();
    commit(0, 4, 1, 32'h11);
    commit(1, 4, 2, 32'h22);
    lookup(0, 4, 0);
    #1;
    vectors++;
    if (obs_j(0) !== {4'd0, 1'b1, 32'h22}) begin
      miscompares++; $display("FAIL dual_fwd: got %h want %h", obs_j(0), {4'd0, 1'b1, 32'h22});
    end
    tick();
    lookup(0, 4, 0);
    #1;
    vectors++;
    if (obs_j(0) !== {4'd0, 1'b1, 32'h22}) begin
      miscompares++; $display("FAIL dual_stored: got %h want %h", obs_j(0), {4'd0, 1'b1, 32'h22});
    end
    $display("[%0t] test_dual_commit done", $time);
    tick();
  endtask

  task automatic test_stale_commit();
    rename(0, 9, 6);
    tick();
    commit(0, 9, 5, 32'hAB);
    lookup(0, 9, 0);
    #1;
    vectors++;
    if (obs_j(0) !== {4'd6, 1'b0, 32'd0}) begin
      miscompares++; $display("FAIL stale_same_cycle: got %h want %h", obs_j(0), {4'd6, 1'b0, 32'd0});
    end
    tick();
    lookup(0, 9, 0);
    #1;
    vectors++;
    if (obs_j(0) !== {4'd6, 1'b0, 32'd0}) begin
      miscompares++; $display("FAIL stale_after: got %h want %h", obs_j(0), {4'd6, 1'b0, 32'd0});
    end
    $display("[%0t] test_stale_commit done", $time);
    tick();
  endtask

  task automatic test_back_to_back();
    rename(0, 11, 1);
    tick();
    commit(0, 11, 1, 32'h99);
    rename(0, 11, 5);
    lookup(0, 11, 0);
    lookup(1, 11, 0);
    #1;
    vectors++;
    if (obs_j(0) !== {4'd0, 1'b1, 32'h99}) begin
      miscompares++; $display("FAIL b2b_l0_fwd: got %h want %h", obs_j(0), {4'd0, 1'b1, 32'h99});
    end
    vectors++;
    if (obs_j(1) !== {4'd5, 1'b0, 32'd0}) begin
      miscompares++; $display("FAIL b2b_l1_rename: got %h want %h", obs_j(1), {4'd5, 1'b0, 32'd0});
    end
    tick();
    lookup(0, 11, 0);
    #1;
    vectors++;
    if (obs_j(0) !== {4'd5, 1'b0, 32'd0}) begin
      miscompares++; $display("FAIL b2b_still_busy: got %h want %h", obs_j(0), {4'd5, 1'b0, 32'd0});
    end
    $display("[%0t] test_back_to_back done", $time);
    tick();
  endtask

  task automatic test_rdy_hold();
    rdy = 1'b0;
    rename(0, 12, 3);
    commit(0, 13, 0, 32'h42);
    lookup(1, 13, 0);
    #1;
    vectors++;
    if (obs_j(1) !== {4'd0, 1'b1, 32'h42}) begin
      miscompares++; $display("FAIL hold_fwd: got %h want %h", obs_j(1), {4'd0, 1'b1, 32'h42});
    end
    tick();
    rdy = 1'b1;
    lookup(0, 12, 13);
    #1;
    vectors++;
    if (obs_j(0) !== {4'd0, 1'b1, 32'd0}) begin
      miscompares++; $display("FAIL hold_no_rename: got %h want %h", obs_j(0), {4'd0, 1'b1, 32'd0});
    end
    vectors++;
    if (obs_k(0) !== {4'd0, 1'b1, 32'd0}) begin
      miscompares++; $display("FAIL hold_no_commit: got %h want %h", obs_k(0), {4'd0, 1'b1, 32'd0});
    end
    $display("[%0t] test_rdy_hold done", $time);
    tick();
  endtask

`ifdef RF_CHECKPOINT_EN
  task automatic test_checkpoint();
    rename(0, 3, 4);
    bus.snap_valid = 1'b1;
    bus.snap_id    = 2'd1;
    tick();
    rename(0, 3, 7);
    tick();
    lookup(0, 3, 0);
    #1;
    vectors++;
    if (obs_j(0) !== {4'd7, 1'b0, 32'd0}) begin
      miscompares++; $display("FAIL ckpt_renamed: got %h want %h", obs_j(0), {4'd7, 1'b0, 32'd0});
    end
    tick();
    commit(0, 3, 4, 32'h3C);
    tick();
    bus.rollback    = 1'b1;
    bus.rollback_id = 2'd1;
    tick();
    lookup(0, 3, 0);
    #1;
    vectors++;
    if (obs_j(0) !== {4'd0, 1'b1, 32'h3C}) begin
      miscompares++; $display("FAIL ckpt_restored: got %h want %h", obs_j(0), {4'd0, 1'b1, 32'h3C});
    end
    $display("[%0t] test_checkpoint done", $time);
    tick();
  endtask
`else
  task automatic test_rollback_flush();
    rename(0, 2, 8);
    rename(1, 3, 9);
    tick();
    lookup(0, 2, 3);
    #1;
    vectors++;
    if (obs_j(0) !== {4'd8, 1'b0, 32'd0}) begin
      miscompares++; $display("FAIL flush_pre_x2: got %h want %h", obs_j(0), {4'd8, 1'b0, 32'd0});
    end
    vectors++;
    if (obs_k(0) !== {4'd9, 1'b0, 32'd0}) begin
      miscompares++; $display("FAIL flush_pre_x3: got %h want %h", obs_k(0), {4'd9, 1'b0, 32'd0});
    end
    tick();
    commit(0, 2, 8, 32'h77);
    bus.rollback = 1'b1;
    tick();
    lookup(0, 2, 3);
    lookup(1, 9, 4);
    #1;
    vectors++;
    if (obs_j(0) !== {4'd0, 1'b1, 32'h77}) begin
      miscompares++; $display("FAIL flush_x2: got %h want %h", obs_j(0), {4'd0, 1'b1, 32'h77});
    end
    vectors++;
    if (obs_k(0) !== {4'd0, 1'b1, 32'd0}) begin
      miscompares++; $display("FAIL flush_x3: got %h want %h", obs_k(0), {4'd0, 1'b1, 32'd0});
    end
    vectors++;
    if (obs_j(1) !== {4'd0, 1'b1, 32'hAB}) begin
      miscompares++; $display("FAIL flush_x9_val: got %h want %h", obs_j(1), {4'd0, 1'b1, 32'hAB});
    end
    vectors++;
    if (obs_k(1) !== {4'd0, 1'b1, 32'h22}) begin
      miscompares++; $display("FAIL flush_x4_val: got %h want %h", obs_k(1), {4'd0, 1'b1, 32'h22});
    end
    $display("[%0t] test_rollback_flush done", $time);
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    rename(0, 5, 3);
    tick();
    lookup(0, 5, 0);
    lookup(1, 4, 0);
    #1;
    vectors++;
    if (obs_j(0) !== {4'd3, 1'b0, 32'd0}) begin
      miscompares++; $display("FAIL midrst_pre: got %h want %h", obs_j(0), {4'd3, 1'b0, 32'd0});
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (obs_j(0) !== {4'd0, 1'b1, 32'd0}) begin
      miscompares++; $display("FAIL midrst_x5: got %h want %h", obs_j(0), {4'd0, 1'b1, 32'd0});
    end
    vectors++;
    if (obs_j(1) !== {4'd0, 1'b1, 32'd0}) begin
      miscompares++; $display("FAIL midrst_x4: got %h want %h", obs_j(1), {4'd0, 1'b1, 32'd0});
    end
    #1;
    rst_n = 1'b1;
    $display("[%0t] test_reset_mid done", $time);
    tick();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    rdy   = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_intra_group();
    test_dual_commit();
    test_stale_commit();
    test_back_to_back();
    test_rdy_hold();
`ifdef RF_CHECKPOINT_EN
    test_checkpoint();
`else
    test_rollback_flush();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
